// File: rtl/present_pkg.sv
// Shared types, inverse S-box table and pLayer-inverse indexing for the PRESENT decryption round.
// Pure declarations: no latency, no backpressure.
package present_pkg;

  typedef logic [63:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  // Entry x sits at bits [4x+3:4x]: 0..F -> 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.
  localparam logic [63:0] SBOX_INV_TBL = 64'hA970_364B_D21C_8FE5;

  localparam int NIBBLES = 16;

  function automatic int sub_cycles(input int npc);
    return NIBBLES / npc;
  endfunction

  function automatic int cnt_width(input int npc);
    return (sub_cycles(npc) > 1) ? $clog2(sub_cycles(npc)) : 1;
  endfunction

  function automatic int p_idx(input int i);
    return (i == 63) ? 63 : (16 * i) % 63;
  endfunction

endpackage

// File: rtl/present_inv_sbox.sv
// Combinational 4-bit PRESENT inverse S-box, zero latency.
// No handshake: output follows input.
module present_inv_sbox
  import present_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  assign o_nib = SBOX_INV_TBL[{i_nib, 2'b00} +: 4];

endmodule

// File: rtl/present_inv_round.sv
// PRESENT decryption round S^-1(P^-1(state_in ^ key)), key XOR only with PRESENT_INV_KEYXOR_EN defined.
// Latency 16/NIBBLES_PER_CYCLE cycles; result held in DONE until out_ready, in_ready low while busy.
module present_inv_round
  import present_pkg::*;
#(
  parameter int NIBBLES_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] state_in,
  input  logic [63:0] round_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] state_out
);

  localparam int            C        = sub_cycles(NIBBLES_PER_CYCLE);
  localparam int            CW       = cnt_width(NIBBLES_PER_CYCLE);
  localparam int            GRP_SH   = $clog2(4 * NIBBLES_PER_CYCLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(C - 1);

  fsm_t          r_state;
  fsm_t          w_state_nxt;
  state_t        r_work;
  state_t        w_mix;
  state_t        w_perm;
  state_t        w_work_sub;
  logic [CW-1:0] r_cnt;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          w_accept;
  logic [5:0]    w_base;
  logic [3:0]    w_sb_in  [NIBBLES_PER_CYCLE];
  logic [3:0]    w_sb_out [NIBBLES_PER_CYCLE];

`ifdef PRESENT_INV_KEYXOR_EN
  assign w_mix = state_in ^ round_key;
`else
  logic w_unused_key;
  assign w_unused_key = ^round_key;
  assign w_mix        = state_in;
`endif

  always_comb begin
    w_perm = '0;
    for (int i = 0; i < 64; i++) begin
      w_perm[i] = w_mix[p_idx(i)];
    end
  end

  // Bit offset of the nibble group handled this cycle.
  assign w_base = 6'(int'(r_cnt) << GRP_SH);

  for (genvar g = 0; g < NIBBLES_PER_CYCLE; g++) begin : g_sbox
    assign w_sb_in[g] = r_work[w_base + 6'(4 * g) +: 4];
    present_inv_sbox u_sbox (
      .i_nib (w_sb_in[g]),
      .o_nib (w_sb_out[g])
    );
  end

  always_comb begin
    w_work_sub = r_work;
    for (int g = 0; g < NIBBLES_PER_CYCLE; g++) begin
      w_work_sub[w_base + 6'(4 * g) +: 4] = w_sb_out[g];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (in_valid && r_in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = SUB;
        end
      end
      SUB: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work      <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      if (w_accept) begin
        r_work <= w_perm;
        r_cnt  <= '0;
      end else if (r_state == SUB) begin
        r_work <= w_work_sub;
        if (r_cnt != CNT_LAST) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign state_out = r_work;

endmodule

// File: tb/tb_present_inv_round.sv
// Directed bench for present_inv_round at N=1, 4 and 16 in parallel, plus forward-round round trips.
// Expected values are hand-derived constants or come from an independent forward PRESENT round.
module tb_present_inv_round;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] state_in;
  logic [63:0] round_key;
  logic [2:0]  w_rdy;
  logic [2:0]  w_vld;
  logic [63:0] w_dat [3];
  int          n_vec = 0;
  int          n_err = 0;

`ifdef PRESENT_INV_KEYXOR_EN
  localparam logic [63:0] EXP_FF = 64'h5555555555555555;
  localparam logic [63:0] EXP_K2 = 64'h55555555555555E5;
`else
  localparam logic [63:0] EXP_FF = 64'hAAAAAAAAAAAAAAAA;
  localparam logic [63:0] EXP_K2 = 64'h5555555555555555;
`endif

  always #5 clk = ~clk;

  present_inv_round #(.NIBBLES_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_rdy[0]),
    .state_in(state_in), .round_key(round_key), .out_valid(w_vld[0]),
    .out_ready(out_ready), .state_out(w_dat[0])
  );

  present_inv_round #(.NIBBLES_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_rdy[1]),
    .state_in(state_in), .round_key(round_key), .out_valid(w_vld[1]),
    .out_ready(out_ready), .state_out(w_dat[1])
  );

  present_inv_round #(.NIBBLES_PER_CYCLE(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_rdy[2]),
    .state_in(state_in), .round_key(round_key), .out_valid(w_vld[2]),
    .out_ready(out_ready), .state_out(w_dat[2])
  );

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 16 : (d == 1) ? 4 : 1;
  endfunction

  function automatic logic [3:0] fwd_sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  // Forward sBoxLayer then pLayer (bit i moves to 16*i mod 63).
  function automatic logic [63:0] fwd_round(input logic [63:0] x);
    logic [63:0] s;
    logic [63:0] p;
    s = '0;
    p = '0;
    for (int n = 0; n < 16; n++) s[n*4 +: 4] = fwd_sbox(x[n*4 +: 4]);
    for (int i = 0; i < 64; i++) p[(i == 63) ? 63 : (i * 16) % 63] = s[i];
    return p;
  endfunction

  task automatic wait_idle();
    int t;
    t = 0;
    while (w_rdy != 3'b111 && t < 40) begin
      tick();
      t++;
    end
    check_vec("idle_wait", {61'd0, w_rdy}, 64'd7);
  endtask

  task automatic run_round(input string tag, input logic [63:0] x, input logic [63:0] k,
                           input logic [63:0] exp);
    logic [63:0] res [3];
    int          lat [3];
    logic [2:0]  seen;
    wait_idle();
    state_in  = x;
    round_key = k;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    state_in  = {$urandom, $urandom};
    round_key = {$urandom, $urandom};
    seen = '0;
    for (int d = 0; d < 3; d++) begin
      res[d] = '0;
      lat[d] = 0;
    end
    for (int j = 1; j <= 40 && seen != 3'b111; j++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        if (w_vld[d] && !seen[d]) begin
          seen[d] = 1'b1;
          lat[d]  = j;
          res[d]  = w_dat[d];
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      check_vec($sformatf("%s_dat_n%0d", tag, d), res[d], exp);
      check_vec($sformatf("%s_lat_n%0d", tag, d), 64'(lat[d]), 64'(lat_of(d)));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] x;
    logic [63:0] k;
    logic [63:0] y;
    int          t;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    state_in  = '0;
    round_key = '0;
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      check_vec($sformatf("rst_rdy_n%0d", d), {63'd0, w_rdy[d]}, 64'd0);
      check_vec($sformatf("rst_vld_n%0d", d), {63'd0, w_vld[d]}, 64'd0);
      check_vec($sformatf("rst_dat_n%0d", d), w_dat[d], 64'd0);
    end
    rst_n = 1'b1;
    tick();
    check_vec("post_rst_rdy", {61'd0, w_rdy}, 64'd7);
    check_vec("post_rst_vld", {61'd0, w_vld}, 64'd0);

    run_round("zero",  64'h0,                64'h0,                64'h5555555555555555);
    run_round("bit1",  64'h0000000000000002, 64'h0,                64'h55555555555555E5);
    run_round("bit63", 64'h8000000000000000, 64'h0,                64'hB555555555555555);
    run_round("allf",  64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, EXP_FF);
    run_round("key2",  64'h0,                64'h0000000000000002, EXP_K2);

    // Backpressure: result must hold and no second round may start.
    wait_idle();
    out_ready = 1'b0;
    state_in  = 64'h0000000000000002;
    round_key = 64'h0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    t = 0;
    while (w_vld != 3'b111 && t < 40) begin
      tick();
      t++;
    end
    check_vec("bp_vld", {61'd0, w_vld}, 64'd7);
    for (int c = 0; c < 10; c++) begin
      in_valid  = ~in_valid;
      state_in  = {$urandom, $urandom};
      round_key = {$urandom, $urandom};
      tick();
      check_vec($sformatf("bp_rdy_c%0d", c), {61'd0, w_rdy}, 64'd0);
      check_vec($sformatf("bp_hold_vld_c%0d", c), {61'd0, w_vld}, 64'd7);
      for (int d = 0; d < 3; d++)
        check_vec($sformatf("bp_dat_c%0d_n%0d", c, d), w_dat[d], 64'h55555555555555E5);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_vec("bp_rel_vld", {61'd0, w_vld}, 64'd0);
    check_vec("bp_rel_rdy", {61'd0, w_rdy}, 64'd7);

    // Reset in the middle of a round discards everything at once.
    wait_idle();
    out_ready = 1'b0;
    state_in  = 64'hFFFFFFFFFFFFFFFF;
    round_key = 64'h0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check_vec($sformatf("mid_rst_vld_n%0d", d), {63'd0, w_vld[d]}, 64'd0);
      check_vec($sformatf("mid_rst_rdy_n%0d", d), {63'd0, w_rdy[d]}, 64'd0);
      check_vec($sformatf("mid_rst_dat_n%0d", d), w_dat[d], 64'd0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    run_round("after_rst", 64'h0, 64'h0, 64'h5555555555555555);

    for (int v = 0; v < 1000; v++) begin
      x = {$urandom, $urandom};
      k = {$urandom, $urandom};
      y = fwd_round(x);
`ifdef PRESENT_INV_KEYXOR_EN
      run_round("trip", y ^ k, k, x);
`else
      run_round("trip", y, k, x);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
